// File: rtl/fpm_share_arbiter_pkg.sv
// fpm_share_pkg: shared widths, default sizing and helpers for the shared multiplier
package fpm_share_pkg;
   localparam int FP_W = 32;
   localparam int N_REQ_DEF = 4;
   localparam int ID_W_DEF = 2;
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/fpm_share_arbiter_if.sv
// fpm_share_arbiter_if: request bus, response port and busy flag of the shared multiplier
interface fpm_share_arbiter_if import fpm_share_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W = ID_W_DEF
);
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [FP_W*N_REQ-1:0] req_a;
   logic [FP_W*N_REQ-1:0] req_b;
   logic rsp_valid;
   logic rsp_ready;
   logic [FP_W-1:0] rsp_product;
   logic [ID_W-1:0] rsp_id;
   logic busy;
   modport master (output req_valid, req_a, req_b, rsp_ready,
                   input req_ready, rsp_valid, rsp_product, rsp_id, busy);
   modport slave (input req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_product, rsp_id, busy);
endinterface

// File: rtl/fpm.sv
// fpm: combinational IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero
module fpm (
   input logic [31:0] a,
   input logic [31:0] b,
   output logic [31:0] p
);
   logic sign, a_zero, b_zero, a_inf, b_inf, nan, g, st, up;
   logic [47:0] m;
   logic [22:0] mant;
   logic [23:0] mr;
   logic [9:0] e_raw;
   // normalise the 48-bit significand product, round, then select special results
   always_comb begin
      sign = a[31] ^ b[31];
      a_zero = a[30:23] == 8'd0;
      b_zero = b[30:23] == 8'd0;
      a_inf = a[30:23] == 8'hFF;
      b_inf = b[30:23] == 8'hFF;
      nan = (a_inf && a[22:0] != 23'd0) || (b_inf && b[22:0] != 23'd0) || (a_inf && b_zero) || (b_inf && a_zero);
      m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      mant = m[47] ? m[46:24] : m[45:23];
      g = m[47] ? m[23] : m[22];
      st = m[47] ? |m[22:0] : |m[21:0];
      up = g & (st | mant[0]);
      mr = {1'b0, mant} + {23'd0, up};
      e_raw = {2'd0, a[30:23]} + {2'd0, b[30:23]} + {9'd0, m[47]} + {9'd0, mr[23]};
      p = nan ? 32'h7FC0_0000 :
          (a_inf || b_inf || e_raw >= 10'd382) ? {sign, 8'hFF, 23'd0} :
          (a_zero || b_zero || e_raw <= 10'd127) ? {sign, 31'd0} :
          {sign, 8'(e_raw - 10'd127), mr[22:0]};
   end
endmodule

// File: rtl/fpm_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves past each accepted winner
module rr_arbiter import fpm_share_pkg::*; #(
   parameter int N = N_REQ_DEF,
   parameter int W = clog2(N)
) (
   input logic clk,
   input logic rst,
   input logic [N-1:0] req,
   input logic advance,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_id
);
   logic [W-1:0] ptr, nxt_ptr;
   logic found;
   int idx;
   // first asserted request in the order ptr, ptr+1, ..., wrapping; nothing while not advancing
   always_comb begin
      grant = '0;
      grant_id = '0;
      nxt_ptr = ptr;
      found = 1'b0;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && advance && req[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            grant_id = W'(idx);
            nxt_ptr = W'((idx + 1) % N);
         end
      end
   end
   // pointer moves only when a grant is actually taken
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (found) ptr <= nxt_ptr;
endmodule

// File: rtl/fpm_share_arbiter.sv
// fpm_share_arbiter: round-robin shares one fpm between requesters through a two-stage pipe
module fpm_share_arbiter import fpm_share_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W = ID_W_DEF
) (
   input logic clk,
   input logic rst,
   fpm_share_arbiter_if.slave bus
);
   logic s1_valid, s2_valid, stall, advance;
   logic [FP_W-1:0] s1_a, s1_b, s2_product, product;
   logic [ID_W-1:0] s1_id, s2_id, gid;
   logic [N_REQ-1:0] grant;
   assign stall = s2_valid & ~bus.rsp_ready;
   assign advance = ~stall & ~rst;
   rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
      .clk(clk), .rst(rst), .req(bus.req_valid), .advance(advance), .grant(grant), .grant_id(gid)
   );
   fpm u_fpm (.a(s1_a), .b(s1_b), .p(product));
   assign bus.req_ready = grant;
   assign bus.rsp_valid = s2_valid;
   assign bus.rsp_product = s2_product;
   assign bus.rsp_id = s2_id;
   assign bus.busy = s1_valid | s2_valid;
   // whole pipe holds on a stall; otherwise S1 feeds S2 and S1 takes the winner
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_id <= '0;
         s2_valid <= 1'b0;
         s2_product <= '0;
         s2_id <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_product <= product;
         s2_id <= s1_id;
         s1_valid <= |grant;
         if (|grant) begin
            s1_a <= bus.req_a[FP_W*int'(gid) +: FP_W];
            s1_b <= bus.req_b[FP_W*int'(gid) +: FP_W];
            s1_id <= gid;
         end
      end
endmodule

// File: tb/tb_fpm_share_arbiter.sv
// tb_fpm_share_arbiter: directed scenario checks of the shared multiplier arbiter
module tb_fpm_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   fpm_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();
   fpm_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b1;
      bus.req_a = '0;
      bus.req_b = '0;
      tick();
      n_chk++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      n_chk++; if (bus.rsp_product !== 32'h0) begin n_fail++; $display("FAIL reset_product got %h want 0", bus.rsp_product); end
      n_chk++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.rsp_id); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      bus.req_valid = 4'h0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      set_op(2, 32'h4000_0000, 32'h4040_0000);
      bus.req_valid = 4'b0100;
      #1;
      n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
      tick();
      bus.req_valid = 4'h0;
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", bus.rsp_valid); end
      n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus.busy); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.rsp_valid); end
      n_chk++; if (bus.rsp_product !== 32'h40C0_0000) begin n_fail++; $display("FAIL single_product got %h want 40c00000", bus.rsp_product); end
      n_chk++; if (bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", bus.rsp_id); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", bus.rsp_valid); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", bus.busy); end
   endtask

   task automatic test_contention();
      logic [31:0] prod [4] = '{32'h4010_0000, 32'h4080_0000, 32'h40C0_0000, 32'hC000_0000};
      int ord [5] = '{0, 1, 2, 3, 0};
      do_reset();
      set_op(0, 32'h3FC0_0000, 32'h3FC0_0000);
      set_op(1, 32'h4000_0000, 32'h4000_0000);
      set_op(2, 32'h4000_0000, 32'h4040_0000);
      set_op(3, 32'hC000_0000, 32'h3F80_0000);
      for (int c = 0; c < 7; c++) begin
         bus.req_valid = (c < 5) ? 4'hF : 4'h0;
         #1;
         if (c < 5) begin
            n_chk++; if (bus.req_ready !== 4'(1 << ord[c])) begin n_fail++; $display("FAIL contention_ready c%0d got %b want %b", c, bus.req_ready, 4'(1 << ord[c])); end
         end
         tick();
         if (c >= 1 && c <= 5) begin
            n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL contention_valid c%0d got %b want 1", c, bus.rsp_valid); end
            n_chk++; if (bus.rsp_id !== 2'(ord[c-1])) begin n_fail++; $display("FAIL contention_id c%0d got %0d want %0d", c, bus.rsp_id, ord[c-1]); end
            n_chk++; if (bus.rsp_product !== prod[ord[c-1]]) begin n_fail++; $display("FAIL contention_product c%0d got %h want %h", c, bus.rsp_product, prod[ord[c-1]]); end
         end else if (c == 6) begin
            n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contention_idle got %b want 0", bus.busy); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] prod [4] = '{32'h4010_0000, 32'h4080_0000, 32'h40C0_0000, 32'hC000_0000};
      logic [3:0] exp_rdy [9] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
      int exp_id [9] = '{-1, 1, 1, 1, 1, 2, 3, 0, -1};
      int acc = 0;
      for (int c = 0; c < 9; c++) begin
         bus.req_valid = (c < 7) ? 4'hF : 4'h0;
         bus.rsp_ready = (c >= 5);
         #1;
         n_chk++; if (bus.req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL bp_ready c%0d got %b want %b", c, bus.req_ready, exp_rdy[c]); end
         if (c < 5) acc += $countones(bus.req_valid & bus.req_ready);
         tick();
         if (exp_id[c] < 0) begin
            n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid c%0d got %b want 0", c, bus.rsp_valid); end
         end else begin
            n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d got %b want 1", c, bus.rsp_valid); end
            n_chk++; if (bus.rsp_id !== 2'(exp_id[c])) begin n_fail++; $display("FAIL bp_id c%0d got %0d want %0d", c, bus.rsp_id, exp_id[c]); end
            n_chk++; if (bus.rsp_product !== prod[exp_id[c]]) begin n_fail++; $display("FAIL bp_product c%0d got %h want %h", c, bus.rsp_product, prod[exp_id[c]]); end
         end
      end
      n_chk++; if (acc != 2) begin n_fail++; $display("FAIL bp_accept_count got %0d want 2", acc); end
   endtask

   task automatic test_fairness();
      logic [31:0] prod [4] = '{32'h4010_0000, 32'h4080_0000, 32'h40C0_0000, 32'hC000_0000};
      logic [3:0] vld [5] = '{4'b0010, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
      logic [3:0] exp_rdy [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
      int exp_id [5] = '{-1, 1, 3, 0, -1};
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bus.req_valid = vld[c];
         #1;
         n_chk++; if (bus.req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL fair_ready c%0d got %b want %b", c, bus.req_ready, exp_rdy[c]); end
         tick();
         if (exp_id[c] < 0) begin
            n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_valid c%0d got %b want 0", c, bus.rsp_valid); end
         end else begin
            n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid c%0d got %b want 1", c, bus.rsp_valid); end
            n_chk++; if (bus.rsp_id !== 2'(exp_id[c])) begin n_fail++; $display("FAIL fair_id c%0d got %0d want %0d", c, bus.rsp_id, exp_id[c]); end
            n_chk++; if (bus.rsp_product !== prod[exp_id[c]]) begin n_fail++; $display("FAIL fair_product c%0d got %h want %h", c, bus.rsp_product, prod[exp_id[c]]); end
         end
      end
   endtask

   task automatic test_sign_zero();
      logic [31:0] opa [4] = '{32'hC000_0000, 32'h0000_0000, 32'h0, 32'h0};
      logic [31:0] opb [4] = '{32'h3F80_0000, 32'h4040_0000, 32'h0, 32'h0};
      logic [31:0] prod [4] = '{32'h0, 32'hC000_0000, 32'h0000_0000, 32'h0};
      for (int c = 0; c < 4; c++) begin
         set_op(1, opa[c], opb[c]);
         bus.req_valid = (c < 2) ? 4'b0010 : 4'b0000;
         #1;
         n_chk++; if (bus.req_ready !== ((c < 2) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL sz_ready c%0d got %b", c, bus.req_ready); end
         tick();
         if (c == 1 || c == 2) begin
            n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sz_valid c%0d got %b want 1", c, bus.rsp_valid); end
            n_chk++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL sz_id c%0d got %0d want 1", c, bus.rsp_id); end
            n_chk++; if (bus.rsp_product !== prod[c]) begin n_fail++; $display("FAIL sz_product c%0d got %h want %h", c, bus.rsp_product, prod[c]); end
         end else begin
            n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sz_valid c%0d got %b want 0", c, bus.rsp_valid); end
         end
      end
   endtask

   task automatic test_reset_midflight();
      set_op(1, 32'h4000_0000, 32'h4000_0000);
      set_op(2, 32'h4000_0000, 32'h4040_0000);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0100;
      tick();
      tick();
      n_chk++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill got busy=%b rsp_valid=%b want 1 1", bus.busy, bus.rsp_valid); end
      bus.req_valid = 4'b1010;
      #2;
      rst = 1'b1;
      #1;
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %b want 0", bus.rsp_valid); end
      n_chk++; if (bus.rsp_product !== 32'h0) begin n_fail++; $display("FAIL mid_product got %h want 0", bus.rsp_product); end
      n_chk++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_id got %0d want 0", bus.rsp_id); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
      n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready got %b want 0000", bus.req_ready); end
      tick();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant got %b want 0010", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      n_chk++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_stale got rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL mid_rsp got valid=%b id=%0d want 1 1", bus.rsp_valid, bus.rsp_id); end
      n_chk++; if (bus.rsp_product !== 32'h4080_0000) begin n_fail++; $display("FAIL mid_product2 got %h want 40800000", bus.rsp_product); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_end got rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_fairness();
      test_sign_zero();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
